onehot2binary: RTL and testbench
================================

# onehot2binary

Registered one-hot to binary encoder with a valid/ready stream interface. It is the inverse of the binary to one-hot converter, so a binary value passed through both blocks returns unchanged. It sits on the return path of decoded select vectors, where it turns grant and select lines back into indices. Inputs that are not one-hot are flagged, and can be counted, instead of being encoded silently.

## Interface
- BITS, default 9: one-hot input width; also the width of the binary output, which matches the converter's binary port.
- CNT_W, default 8: error counter width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input vector present.
- o_ready  out  1  encoder can accept this cycle.
- i_onehot  in  BITS  one-hot vector.
- o_valid  out  1  result present.
- i_ready  in  1  downstream accepts the result.
- o_nkb  out  BITS  encoded index, zero-extended.
- o_zero  out  1  the input had no bit set.
- o_multi  out  1  the input had more than one bit set.
- i_clr  in  1  clear the error counter (counter build only).
- o_errcnt  out  CNT_W  saturating error count (counter build only).

## Operation
- Two-stage pipeline: stage 1 (S1) and stage 2 (S2). Each stage holds one valid bit and its data.
- S1 registers i_onehot.
- S2 computes and registers o_nkb, o_zero and o_multi from the S1 data.
- Encoding:
  - o_nkb is the index of the lowest set bit.
  - Zero vector: o_nkb=0 and o_zero=1.
  - Two or more bits set: o_multi=1, and o_nkb still reports the lowest set index.
  - o_zero and o_multi are never both 1.
- An accept (input handshake) happens when i_valid && o_ready. A consume (output handshake) happens when o_valid && i_ready.
- S2 loads when S1 is valid and S2 is empty or being consumed this cycle.
- S1 loads on an accept. If S1 is simultaneously moving to S2, it reloads with the new input in the same cycle.
- o_ready = !S1.valid || S2 loads this cycle. This is combinational from i_ready; there is no combinational path from i_valid to o_ready.
- Output stability: while o_valid=1 and i_ready=0, o_nkb, o_zero and o_multi hold constant.
- Error counter:
  - Increments on each consumed result with o_zero|o_multi.
  - Saturates at 2^CNT_W-1.
  - i_clr sets it to 0. When i_clr coincides with an erroring consume, the counter becomes 0 (clear wins).

## Timing
- Reset (i_rst=1 on a rising edge) sets both valid bits to 0 and the counter to 0.
  - During and after reset: o_valid=0, o_nkb=0, o_zero=0, o_multi=0, o_errcnt=0.
  - o_ready is 1 in the first cycle after reset.
- Reset mid-operation discards any data in flight. No result is produced for it.
- Latency: input accepted at edge N, o_valid=1 after edge N+1 when S2 was empty.
- Throughput: one result per cycle with i_ready held at 1.
- Backpressure:
  - With i_ready=0, the block accepts at most 2 inputs, then o_ready=0.
  - The first cycle i_ready=1 frees a slot, and o_ready=1 in that same cycle.
- The counter updates on the edge of the consume; o_errcnt is registered.

## Configuration
- ONEHOT2BINARY_ERRCNT_EN:
  - Defined: the error counter is built, i_clr is sampled, and o_errcnt is driven as described under Operation.
  - Undefined: no counter register, i_clr is ignored, o_errcnt is tied to 0.
- Port list is identical in both builds.

## Structure
- Package onehot2binary_pkg:
  - typedef of the S2 result struct (nkb, zero, multi).
  - Function lowest_set_index(BITS-wide vector).
  - Function classify() returning an enum {OH_ZERO, OH_ONE, OH_MULTI}.
- One sub-module, onehot2binary_stage: a generic valid/ready pipeline register with a payload-width parameter. It is instantiated twice.
- The counter lives in the top level, inside `ifdef`.

## Test plan
- Single accept: reset, then i_onehot=9'b000100000 with i_ready=1 → o_valid rises 2 cycles later with o_nkb=5, o_zero=0, o_multi=0.
- Round trip: drive each binary value 0..8 through the existing converter into this block with i_ready=1 → o_nkb equals the value and o_multi=0 for every value. Streamed back-to-back, one result per cycle.
- Invalid inputs:
  - i_onehot=9'b0 → o_zero=1, o_nkb=0.
  - 9'b100001000 → o_multi=1, o_nkb=3.
  - Counter build: o_errcnt=2 after both are consumed.
- Backpressure:
  - Hold i_ready=0 and offer inputs 1, 2, 4 → only two are accepted and o_ready=0.
  - Raise i_ready → results for indices 0 then 1, then 2, in order, with no loss or duplication.
- Counter limits:
  - CNT_W=2 with 5 zero vectors → o_errcnt saturates at 3.
  - i_clr asserted together with an erroring consume → o_errcnt=0.
- Mid-flight reset: assert i_rst with both stages full → o_valid=0 next cycle and o_errcnt=0. The first post-reset input, 9'b000000001, yields o_nkb=0 with no stale result before it.

Source files
------------

// File: rtl/onehot2binary_pkg.sv
// onehot2binary_pkg: shared types and encoding helpers for the one-hot to binary encoder.
// Helpers work on a zero-extended OH_MAX_W vector so any BITS up to OH_MAX_W can use them.
package onehot2binary_pkg;

    localparam int OH_MAX_W = 32;

    typedef enum logic [1:0] {
        OH_ZERO,
        OH_ONE,
        OH_MULTI
    } oh_class_e;

    typedef struct packed {
        logic [31:0] nkb;
        logic        zero;
        logic        multi;
    } oh_result_t;

    function automatic logic [31:0] lowest_set_index(input logic [OH_MAX_W-1:0] vec);
        logic [31:0] idx;
        idx = '0;
        for (int i = OH_MAX_W - 1; i >= 0; i--) begin
            if (vec[i]) idx = 32'(i);
        end
        return idx;
    endfunction

    function automatic oh_class_e classify(input logic [OH_MAX_W-1:0] vec);
        if (vec == '0) return OH_ZERO;
        if ((vec & (vec - OH_MAX_W'(1))) != '0) return OH_MULTI;
        return OH_ONE;
    endfunction

endpackage

// File: rtl/onehot2binary_stage.sv
// onehot2binary_stage: one valid/ready pipeline register slot with a W-bit payload.
// Ready looks through to downstream, so a full slot still accepts when it is being drained.
module onehot2binary_stage #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    assign o_ready = !valid_q || i_ready;
    assign load    = i_valid && o_ready;
    assign o_valid = valid_q;
    assign o_data  = data_q;

    // Next-state: load on handshake, drop valid when drained, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = i_data;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot register; data is cleared on reset so outputs read zero afterwards.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/onehot2binary.sv
// onehot2binary: registered one-hot to binary encoder, two-slot valid/ready pipeline.
// Optional saturating error counter built when ONEHOT2BINARY_ERRCNT_EN is defined.
// BITS must not exceed onehot2binary_pkg::OH_MAX_W.
module onehot2binary
    import onehot2binary_pkg::*;
#(
    parameter int unsigned BITS  = 9,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [BITS-1:0]  i_onehot,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [BITS-1:0]  o_nkb,
    output logic             o_zero,
    output logic             o_multi,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_errcnt
);

    logic              s1_valid, s2_ready;
    logic [BITS-1:0]   s1_data;
    logic [BITS+1:0]   s2_in, s2_data;
    logic [OH_MAX_W-1:0] vec_ext;
    oh_class_e         cls;
    oh_result_t        res;

    onehot2binary_stage #(.W(BITS)) u_s1 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_onehot),
        .o_valid (s1_valid),
        .i_ready (s2_ready),
        .o_data  (s1_data)
    );

    // Encode the S1 vector: lowest set index plus zero/multi flags.
    always_comb begin
        vec_ext   = OH_MAX_W'(s1_data);
        cls       = classify(vec_ext);
        res.nkb   = lowest_set_index(vec_ext);
        res.zero  = (cls == OH_ZERO);
        res.multi = (cls == OH_MULTI);
    end

    assign s2_in = {BITS'(res.nkb), res.zero, res.multi};

    onehot2binary_stage #(.W(BITS + 2)) u_s2 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (s1_valid),
        .o_ready (s2_ready),
        .i_data  (s2_in),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (s2_data)
    );

    assign {o_nkb, o_zero, o_multi} = s2_data;

`ifdef ONEHOT2BINARY_ERRCNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consumed error results, saturating; clear has priority.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (o_valid && i_ready && (o_zero || o_multi) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Error counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign o_errcnt = cnt_q;
`else
    logic unused_clr;
    assign unused_clr = i_clr;
    assign o_errcnt   = '0;
`endif

endmodule

// File: tb/tb_onehot2binary.sv
// tb_onehot2binary: table vectors, hand sequences and random traffic against a queue model.
module tb_onehot2binary;

    localparam int BITS = 9;
`ifdef ONEHOT2BINARY_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            i_clk = 1'b0;
    logic            i_rst, i_valid, i_ready, i_clr;
    logic [BITS-1:0] i_onehot;
    logic            o_ready, o_valid, o_zero, o_multi;
    logic [BITS-1:0] o_nkb;
    logic [7:0]      o_errcnt;
    logic            s_ready, s_valid, s_zero, s_multi;
    logic [BITS-1:0] s_nkb;
    logic [1:0]      s_errcnt;

    onehot2binary #(.BITS(BITS), .CNT_W(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_onehot(i_onehot), .o_valid(o_valid), .i_ready(i_ready), .o_nkb(o_nkb),
        .o_zero(o_zero), .o_multi(o_multi), .i_clr(i_clr), .o_errcnt(o_errcnt)
    );

    onehot2binary #(.BITS(BITS), .CNT_W(2)) dut2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(s_ready),
        .i_onehot(i_onehot), .o_valid(s_valid), .i_ready(i_ready), .o_nkb(s_nkb),
        .o_zero(s_zero), .o_multi(s_multi), .i_clr(i_clr), .o_errcnt(s_errcnt)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [BITS-1:0] oh;
        int              age;
    } ent_t;
    ent_t q[$];
    int   got[$];
    int   m_cnt8 = 0;
    int   m_cnt2 = 0;

    typedef struct {
        logic [BITS-1:0] oh;
        int              nkb;
        bit              zero;
        bit              multi;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int low_idx(input logic [BITS-1:0] v);
        for (int i = 0; i < BITS; i++) if (v[i]) return i;
        return 0;
    endfunction

    // One clock: compare DUTs with model, then advance model across the edge.
    task automatic cycle();
        bit m_valid, m_ready, acc, con, err;
        logic [BITS-1:0] h;
        #1;
        m_valid = (q.size() > 0) && (q[0].age >= 1);
        m_ready = (q.size() < 2) || i_ready;
        h       = m_valid ? q[0].oh : '0;
        chk("ready", 32'(o_ready), 32'(m_ready));
        chk("valid", 32'(o_valid), 32'(m_valid));
        chk("ready2", 32'(s_ready), 32'(m_ready));
        chk("valid2", 32'(s_valid), 32'(m_valid));
        if (m_valid) begin
            chk("nkb", 32'(o_nkb), 32'(low_idx(h)));
            chk("zero", 32'(o_zero), 32'($countones(h) == 0));
            chk("multi", 32'(o_multi), 32'($countones(h) > 1));
            chk("nkb2", 32'(s_nkb), 32'(low_idx(h)));
            chk("flags2", 32'({s_zero, s_multi}), 32'({$countones(h) == 0, $countones(h) > 1}));
        end
        chk("errcnt", 32'(o_errcnt), 32'(m_cnt8));
        chk("errcnt2", 32'(s_errcnt), 32'(m_cnt2));
        acc = i_valid && m_ready;
        con = m_valid && i_ready;
        err = con && ($countones(h) != 1);
        if (o_valid && i_ready && !i_rst) got.push_back(int'(o_nkb));
        @(posedge i_clk);
        if (i_rst) begin
            q.delete();
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else begin
            if (con) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (acc) q.push_back('{oh: i_onehot, age: 0});
            if (CNT_EN) begin
                if (i_clr) begin
                    m_cnt8 = 0;
                    m_cnt2 = 0;
                end else if (err) begin
                    if (m_cnt8 < 255) m_cnt8++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end
        end
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BITS-1:0] one;
        one = 1;
        vt[0] = '{9'b000100000, 5, 1'b0, 1'b0};
        vt[1] = '{9'b000000000, 0, 1'b1, 1'b0};
        vt[2] = '{9'b100001000, 3, 1'b0, 1'b1};
        vt[3] = '{9'b000000001, 0, 1'b0, 1'b0};
        vt[4] = '{9'b100000000, 8, 1'b0, 1'b0};
        vt[5] = '{9'b111111111, 0, 1'b0, 1'b1};
        vt[6] = '{9'b000000110, 1, 1'b0, 1'b1};

        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_clr = 1'b0; i_onehot = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_nkb", 32'(o_nkb), 32'd0);
        chk("rst_flags", 32'({o_zero, o_multi}), 32'd0);
        chk("rst_errcnt", 32'(o_errcnt), 32'd0);
        i_rst = 1'b0;
        #1;
        chk("rst_ready", 32'(o_ready), 32'd1);

        // Latency: accept, then result visible one edge later.
        i_valid = 1'b1; i_onehot = 9'b000100000;
        cycle();
        i_valid = 1'b0;
        chk("lat_early", 32'(o_valid), 32'd0);
        cycle();
        chk("lat_valid", 32'(o_valid), 32'd1);
        chk("lat_nkb", 32'(o_nkb), 32'd5);
        cycle();

        // Table vectors, one at a time.
        for (int k = 0; k < 7; k++) begin
            i_valid = 1'b1; i_onehot = vt[k].oh;
            cycle();
            i_valid = 1'b0;
            cycle();
            chk("tbl_nkb", 32'(o_nkb), 32'(vt[k].nkb));
            chk("tbl_flags", 32'({o_zero, o_multi}), 32'({vt[k].zero, vt[k].multi}));
            cycle();
            if (k == 2) chk("errcnt_two", 32'(o_errcnt), CNT_EN ? 32'd2 : 32'd0);
        end

        // Round trip of every index, streamed back to back.
        got.delete();
        for (int v = 0; v < BITS; v++) begin
            i_valid = 1'b1; i_onehot = one << v;
            cycle();
        end
        i_valid = 1'b0;
        repeat (3) cycle();
        chk("rt_count", 32'(got.size()), 32'(BITS));
        foreach (got[i]) chk("rt_value", 32'(got[i]), 32'(i));

        // Backpressure: only two accepted, third taken once ready rises.
        got.delete();
        i_ready = 1'b0; i_valid = 1'b1;
        i_onehot = 9'd1; cycle();
        i_onehot = 9'd2; cycle();
        i_onehot = 9'd4; cycle();
        chk("bp_full", 32'(o_ready), 32'd0);
        cycle();
        i_ready = 1'b1;
        #1;
        chk("bp_free", 32'(o_ready), 32'd1);
        cycle();
        i_valid = 1'b0;
        repeat (4) cycle();
        chk("bp_count", 32'(got.size()), 32'd3);
        foreach (got[i]) chk("bp_order", 32'(got[i]), 32'(i));

        // Clear coinciding with an erroring consume.
        i_ready = 1'b0; i_valid = 1'b1; i_onehot = '0;
        cycle();
        i_valid = 1'b0;
        cycle();
        i_ready = 1'b1; i_clr = 1'b1;
        cycle();
        i_clr = 1'b0;
        chk("clr_wins", 32'(o_errcnt), 32'd0);

        // Saturation of the narrow counter with five zero vectors.
        i_valid = 1'b1; i_onehot = '0;
        repeat (5) cycle();
        i_valid = 1'b0;
        repeat (3) cycle();
        chk("sat2", 32'(s_errcnt), CNT_EN ? 32'd3 : 32'd0);
        chk("sat8", 32'(o_errcnt), CNT_EN ? 32'd5 : 32'd0);

        // Reset with both stages full.
        i_ready = 1'b0; i_valid = 1'b1;
        i_onehot = 9'b000010000; cycle();
        i_onehot = 9'b001000000; cycle();
        i_valid = 1'b0; i_rst = 1'b1;
        cycle();
        chk("mrst_valid", 32'(o_valid), 32'd0);
        chk("mrst_errcnt", 32'(o_errcnt), 32'd0);
        i_rst = 1'b0; i_ready = 1'b1;
        got.delete();
        i_valid = 1'b1; i_onehot = 9'b000000001;
        cycle();
        i_valid = 1'b0;
        repeat (3) cycle();
        chk("mrst_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("mrst_first", 32'(got[0]), 32'd0);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_clr   = ($urandom_range(0, 40) == 0);
            case ($urandom_range(0, 3))
                0:       i_onehot = '0;
                3:       i_onehot = BITS'($urandom);
                default: i_onehot = one << $urandom_range(0, BITS - 1);
            endcase
            cycle();
        end
        i_valid = 1'b0; i_ready = 1'b1; i_clr = 1'b0;
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
